mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-ported data/instruction RAM between the instruction-fetch unit (port F, read-only) and the load/store unit (port D, read/write). It sits between the core and the RAM macro. It grants at most one access per cycle, drives the RAM chip-select, address, write data and byte mask, and routes the one-cycle-late read data back to the requesting port. It also rejects out-of-range addresses with an error response and never touches the RAM for them.

## Interface
- ADDR_WIDTH, 32, request and RAM address width (bytes).
- DATA_WIDTH, 32, data width; the byte-mask width is DATA_WIDTH/8.
- MEM_BYTES, 65536, RAM size in bytes; valid addresses are 0 .. MEM_BYTES-1.
- STARVE_LIMIT, 4, consecutive denied cycles of port F after which F is forced a grant (fixed-priority mode only).
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- f_req_i  in  1  fetch request; held with f_addr_i stable until granted.
- f_addr_i  in  ADDR_WIDTH  fetch byte address.
- f_gnt_o  out  1  fetch request accepted this cycle (combinational).
- f_rvalid_o  out  1  fetch response pulse, one cycle.
- f_rdata_o  out  DATA_WIDTH  fetch read data, valid with f_rvalid_o.
- f_err_o  out  1  fetch error flag, valid with f_rvalid_o.
- d_req_i  in  1  data request; held with d_addr_i, d_wdata_i and d_wmask_i stable until granted.
- d_addr_i  in  ADDR_WIDTH  data byte address.
- d_wdata_i  in  DATA_WIDTH  store data, byte-lane aligned.
- d_wmask_i  in  4  byte write enables; 0 means read.
- d_gnt_o  out  1  data request accepted this cycle (combinational).
- d_rvalid_o  out  1  data response pulse (read data or write ack).
- d_rdata_o  out  DATA_WIDTH  load data; 0 for writes.
- d_err_o  out  1  data error flag.
- ram_en_o  out  1  RAM chip select.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address; RAM drops bits [1:0].
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_wmask_o  out  4  RAM byte mask.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, registered in the RAM, valid the cycle after ram_en_o.

## Operation
- Arbitration runs every cycle over the inputs f_req_i and d_req_i. At most one gnt is high per cycle, and a gnt is only asserted while its req is high.
- Single request: that request is granted immediately.
- Both requests present: the winner is chosen by the configured policy (see Configuration).
- A granted in-range request drives ram_en_o=1. The grant routes that port's address to ram_addr_o; it also routes d_wdata_i/d_wmask_i for port D, or 0/0 for port F.
- Out-of-range request (addr >= MEM_BYTES): it is still granted, ram_en_o stays 0, and the response carries err=1 with rdata=0.
- Response register captures port, is_read and err at the grant edge.
- In the next cycle, exactly that port's rvalid pulses high for one cycle.
- rdata is taken from ram_rdata_i for in-range reads, and is 0 for writes and errors.
- Responses cannot be back-pressured; requesters must capture them on the rvalid cycle.
- Throughput is one access per cycle. A grant may coincide with the previous access's response.
- When no grant occurs, the RAM outputs are ram_en_o=0 and ram_addr/wdata/wmask=0.

## Timing
- Reset values: rvalid, err and rdata are 0 on both ports; ram_en_o=0; response register cleared; starvation counter 0; round-robin pointer = D (so F wins the first tie).
- While reset_n=0, both gnt outputs are forced to 0.
- Latency: request granted in cycle N → response in cycle N+1, for reads, writes and errors alike.
- A write is committed to the RAM at the grant edge. A read of the same word granted in cycle N+1 returns the new data.
- Reset mid-access: a pending response is discarded and no rvalid is issued after reset is released.
- Starvation counter:
  - Increments each cycle F requests and is denied.
  - Clears when F is granted or f_req_i=0.
  - Saturates at STARVE_LIMIT.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on ties. The port not granted on the last tie wins the next tie, and the pointer updates only on tie cycles. The starvation counter is not built.
- MEM_ARB_RR_EN undefined: fixed priority, D over F. The exception is when the starvation counter equals STARVE_LIMIT; then F wins that tie and the counter clears.

## Test plan
- Read after reset: D writes 0xDEADBEEF, mask 4'hF, at 0x100. Then F reads 0x100 → F gets f_rvalid_o one cycle after its grant, with f_rdata_o=0xDEADBEEF and f_err_o=0.
- Byte write: D writes 0x000000AA with mask 4'b0001 to a word holding 0x11223344, then D reads it back → d_rdata_o=0x112233AA. The write ack has d_rdata_o=0.
- Tie, fixed priority: both ports request every cycle, STARVE_LIMIT=4 → grants follow D,D,D,D,F, repeating. There is exactly one rvalid per cycle, routed to the correct port.
- Tie, MEM_ARB_RR_EN: both ports request continuously → grants alternate F,D,F,D starting with F after reset.
- Out of range: F reads 0x10000 → ram_en_o stays 0; the next cycle has f_rvalid_o=1, f_err_o=1 and f_rdata_o=0.
- Reset mid-access: assert reset_n=0 in the cycle after a D read grant → d_rvalid_o stays 0. All outputs hold their reset values, and no stale response appears after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch (F) and load/store (D).
// Define MEM_ARB_RR_EN for round-robin ties; default is D-over-F with an F starvation guard.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_BYTES    = 65536,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    f_req_i,
    input  logic [ADDR_WIDTH-1:0]   f_addr_i,
    output logic                    f_gnt_o,
    output logic                    f_rvalid_o,
    output logic [DATA_WIDTH-1:0]   f_rdata_o,
    output logic                    f_err_o,
    input  logic                    d_req_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_wmask_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_err_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_wmask_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
    localparam int          MW      = DATA_WIDTH/8;
    localparam logic [63:0] MEM_TOP = 64'(MEM_BYTES);

    logic                  w_f_inr, w_d_inr, w_f_win;
    logic                  w_f_gnt, w_d_gnt, w_any, w_inr, w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  r_vld, r_port_f, r_rd, r_err;

    assign w_f_inr = 64'(f_addr_i) < MEM_TOP;
    assign w_d_inr = 64'(d_addr_i) < MEM_TOP;

`ifdef MEM_ARB_RR_EN
    // r_rr_last_f remembers who won the last tie; reset to D so F wins the first.
    logic w_tie;
    logic r_rr_last_f;
    assign w_tie   = f_req_i & d_req_i;
    assign w_f_win = f_req_i & (~d_req_i | ~r_rr_last_f);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   r_rr_last_f <= 1'b0;
        else if (w_tie) r_rr_last_f <= w_f_win;
    end
`else
    localparam int CW = $clog2(STARVE_LIMIT+1);
    logic [CW-1:0] r_starve;
    logic          w_starved;
    assign w_starved = (r_starve == CW'(STARVE_LIMIT));
    assign w_f_win   = f_req_i & (~d_req_i | w_starved);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  r_starve <= '0;
        else if (!f_req_i || w_f_gnt)  r_starve <= '0;
        else if (!w_starved)           r_starve <= r_starve + 1'b1;
    end
`endif

    assign w_f_gnt = reset_n & w_f_win;
    assign w_d_gnt = reset_n & d_req_i & ~w_f_win;
    assign f_gnt_o = w_f_gnt;
    assign d_gnt_o = w_d_gnt;

    assign w_any  = w_f_gnt | w_d_gnt;
    assign w_addr = w_f_gnt ? f_addr_i : d_addr_i;
    assign w_inr  = w_f_gnt ? w_f_inr : w_d_inr;
    assign w_en   = w_any & w_inr;

    // Out-of-range grants leave the RAM bus fully idle.
    assign ram_en_o    = w_en;
    assign ram_addr_o  = w_en ? w_addr : '0;
    assign ram_wdata_o = (w_en & w_d_gnt) ? d_wdata_i : '0;
    assign ram_wmask_o = (w_en & w_d_gnt) ? d_wmask_i : {MW{1'b0}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld    <= 1'b0;
            r_port_f <= 1'b0;
            r_rd     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_vld    <= w_any;
            r_port_f <= w_f_gnt;
            r_rd     <= w_f_gnt | ~|d_wmask_i;
            r_err    <= w_any & ~w_inr;
        end
    end

    assign w_rdata    = (r_vld & r_rd & ~r_err) ? ram_rdata_i : '0;
    assign f_rvalid_o = r_vld & r_port_f;
    assign f_rdata_o  = r_port_f ? w_rdata : '0;
    assign f_err_o    = r_vld & r_port_f & r_err;
    assign d_rvalid_o = r_vld & ~r_port_f;
    assign d_rdata_o  = r_port_f ? '0 : w_rdata;
    assign d_err_o    = r_vld & ~r_port_f & r_err;

endmodule
